// File: rtl/game_flow_ctrl_pkg.sv
// game_flow_ctrl_pkg: game-flow state encoding and BCD digit width, shared with the score display driver
package game_flow_ctrl_pkg;
  localparam int DIGIT_W = 4;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    MISS  = 3'd3,
    OVER  = 3'd4
  } state_t;
endpackage

// File: rtl/game_flow_ctrl_if.sv
// game_flow_ctrl_if: pulses from the ball datapath and the flow controls/display it receives back
interface game_flow_ctrl_if import game_flow_ctrl_pkg::*; ();
  logic                   frame_tick;
  logic                   start;
  logic                   paddle_hit;
  logic                   ball_miss;
  logic                   ball_hold;
  logic                   ball_run;
  logic [3:0]             speed_level;
  logic [4*DIGIT_W-1:0]   score_bcd;
  logic [1:0]             lives;
  logic                   game_over;
  modport slave (
    input  frame_tick, start, paddle_hit, ball_miss,
    output ball_hold, ball_run, speed_level, score_bcd, lives, game_over
  );
  modport master (
    output frame_tick, start, paddle_hit, ball_miss,
    input  ball_hold, ball_run, speed_level, score_bcd, lives, game_over
  );
endinterface

// File: rtl/game_flow_ctrl_bcd_counter4.sv
// bcd_counter4: 4-digit BCD incrementer with synchronous clear, wraps 9999 to 0000
module bcd_counter4 import game_flow_ctrl_pkg::*; (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr_i,
  input  logic                 inc_i,
  output logic [4*DIGIT_W-1:0] bcd_o
);
  logic [4*DIGIT_W-1:0] bcd_q, bcd_d;
  logic [3:0]           carry;
  assign carry[0] = inc_i;
  for (genvar i = 0; i < 4; i++) begin : g_dig
    logic [DIGIT_W-1:0] dig;
    assign dig = bcd_q[i*DIGIT_W +: DIGIT_W];
    if (i < 3) begin : g_carry
      assign carry[i+1] = carry[i] && dig == DIGIT_W'(9);
    end
    assign bcd_d[i*DIGIT_W +: DIGIT_W] = clr_i ? '0 : !carry[i] ? dig :
                                         dig == DIGIT_W'(9) ? '0 : dig + 1'b1;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) bcd_q <= '0;
    else       bcd_q <= bcd_d;
  assign bcd_o = bcd_q;
endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: per-frame serve/play/miss sequencer with lives, BCD score and speed level
module game_flow_ctrl import game_flow_ctrl_pkg::*; #(
  parameter int LIVES        = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int MISS_FRAMES  = 30,
  parameter int HITS_PER_LVL = 4,
  parameter int MAX_LVL      = 7
) (
  input logic             clk,
  input logic             reset,
  game_flow_ctrl_if.slave bus
);
  localparam int FW = $clog2((SERVE_FRAMES > MISS_FRAMES ? SERVE_FRAMES : MISS_FRAMES) + 1);
  localparam int HW = $clog2(HITS_PER_LVL + 1);
  localparam logic [FW-1:0] SERVE_LAST = FW'(SERVE_FRAMES - 1);
  localparam logic [FW-1:0] MISS_LAST  = FW'(MISS_FRAMES - 1);
  localparam logic [HW-1:0] HIT_LAST   = HW'(HITS_PER_LVL - 1);
  state_t          state_q, state_d;
  logic            start_q, start_rise, serve_done, miss_done;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic [HW-1:0]   hit_q, hit_d;
  logic [3:0]      lvl_q, lvl_d;
  logic [1:0]      lives_q, lives_d;
  logic            hold_q, hold_d, run_q, run_d, over_q, over_d;
  logic            score_clr, score_inc;
  assign start_rise = bus.start && !start_q;
  assign serve_done = bus.frame_tick && fcnt_q == SERVE_LAST;
  assign miss_done  = bus.frame_tick && fcnt_q == MISS_LAST;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      fcnt_q  <= '0;
      hit_q   <= '0;
      lvl_q   <= '0;
      lives_q <= 2'(LIVES);
      hold_q  <= 1'b1;
      run_q   <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= bus.start;
      fcnt_q  <= fcnt_d;
      hit_q   <= hit_d;
      lvl_q   <= lvl_d;
      lives_q <= lives_d;
      hold_q  <= hold_d;
      run_q   <= run_d;
      over_q  <= over_d;
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start_rise ? SERVE : IDLE;
      SERVE:   state_d = serve_done ? PLAY : SERVE;
      PLAY:    state_d = bus.ball_miss ? MISS : PLAY;
      MISS:    state_d = !miss_done ? MISS : lives_q != 2'd0 ? SERVE : OVER;
      OVER:    state_d = start_rise ? IDLE : OVER;
      default: state_d = IDLE;
    endcase
  end
  // A miss pre-empts a hit in the same cycle and restarts the frame count, so a coincident tick is not counted.
  always_comb begin
    fcnt_d    = fcnt_q;
    hit_d     = hit_q;
    lvl_d     = lvl_q;
    lives_d   = lives_q;
    score_clr = 1'b0;
    score_inc = 1'b0;
    case (state_q)
      IDLE: if (start_rise) begin
        score_clr = 1'b1;
        lives_d   = 2'(LIVES);
        lvl_d     = '0;
        fcnt_d    = '0;
        hit_d     = '0;
      end
      SERVE: if (bus.frame_tick) fcnt_d = serve_done ? '0 : fcnt_q + 1'b1;
      PLAY: if (bus.ball_miss) begin
        lives_d = lives_q - 2'd1;
        lvl_d   = '0;
        hit_d   = '0;
        fcnt_d  = '0;
      end else if (bus.paddle_hit) begin
        score_inc = 1'b1;
        hit_d     = hit_q == HIT_LAST ? '0 : hit_q + 1'b1;
        lvl_d     = hit_q == HIT_LAST && lvl_q != 4'(MAX_LVL) ? lvl_q + 4'd1 : lvl_q;
      end
      MISS: if (bus.frame_tick) fcnt_d = miss_done ? '0 : fcnt_q + 1'b1;
      default: ;
    endcase
  end
  always_comb begin
    hold_d = state_d == IDLE || state_d == SERVE || state_d == OVER;
    run_d  = state_d == PLAY;
    over_d = state_d == OVER;
  end
  bcd_counter4 u_score (
    .clk   (clk),
    .reset (reset),
    .clr_i (score_clr),
    .inc_i (score_inc),
    .bcd_o (bus.score_bcd)
  );
  assign bus.ball_hold   = hold_q;
  assign bus.ball_run    = run_q;
  assign bus.speed_level = lvl_q;
  assign bus.lives       = lives_q;
  assign bus.game_over   = over_q;
endmodule
